// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO responder.
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST2,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_RD_TA,
    S_RD_DATA,
    S_WR_TA,
    S_WR_DATA,
    S_SKIP
  } mdio_state_t;

  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam int MDIO_PHYAD_BITS = 5;
  localparam int MDIO_REGAD_BITS = 5;
  localparam int MDIO_DATA_BITS  = 16;
  localparam int MDIO_TA_BITS    = 2;
  localparam int MDIO_SKIP_BITS  = MDIO_TA_BITS + MDIO_DATA_BITS;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for mdCLK and MDIO with an mdCLK rising-edge pulse.
// Rise pulse appears 2 CLK after the pad edge; no backpressure.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic rise,
  output logic bit_val
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  // Reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q  <= '1;
      mdio_q <= '1;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio};
    end
  end

  assign rise    = mdc_q[1] & ~mdc_q[2];
  assign bit_val = mdio_q[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder: frame decode, read drive-back, write strobe.
// Acts 3 CLK after each mdCLK rise; no backpressure, a stalled mdCLK simply holds state.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mdCLK,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  localparam logic [4:0] PHY_LAST  = 5'(MDIO_PHYAD_BITS - 1);
  localparam logic [4:0] REG_LAST  = 5'(MDIO_REGAD_BITS - 1);
  localparam logic [4:0] TA_LAST   = 5'(MDIO_TA_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(MDIO_DATA_BITS - 1);
  localparam logic [4:0] RD_END    = 5'(MDIO_DATA_BITS);
  localparam logic [4:0] SKIP_LAST = 5'(MDIO_SKIP_BITS - 1);

  logic mdc_rise;
  logic mdio_bit;

  mdio_sync_edge u_sync (
    .clk     (CLK),
    .rst     (RST),
    .mdc     (mdCLK),
    .mdio    (mdio_i),
    .rise    (mdc_rise),
    .bit_val (mdio_bit)
  );

  mdio_state_t state, state_nxt;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic        hi_bit, hi_bit_nxt;
  logic        is_rd, is_rd_nxt;
  logic [3:0]  phy_sr, phy_sr_nxt;
  logic [15:0] shift, shift_nxt;
  logic        mdio_o_nxt, mdio_oe_nxt;
  logic [4:0]  reg_addr_nxt;
  logic        reg_wr_en_nxt;
  logic [15:0] reg_wr_data_nxt;
  logic        frame_err_nxt;
  logic        pre_sat;

  assign pre_sat = (pre_cnt == PRE_W'(PREAMBLE_LEN));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      hi_bit      <= 1'b0;
      is_rd       <= 1'b0;
      phy_sr      <= '0;
      shift       <= '0;
      mdio_o      <= 1'b1;
      mdio_oe     <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pre_cnt     <= pre_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      hi_bit      <= hi_bit_nxt;
      is_rd       <= is_rd_nxt;
      phy_sr      <= phy_sr_nxt;
      shift       <= shift_nxt;
      mdio_o      <= mdio_o_nxt;
      mdio_oe     <= mdio_oe_nxt;
      reg_addr    <= reg_addr_nxt;
      reg_wr_en   <= reg_wr_en_nxt;
      reg_wr_data <= reg_wr_data_nxt;
      frame_err   <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pre_cnt_nxt     = (state == S_IDLE) ? pre_cnt : '0;
    bit_cnt_nxt     = bit_cnt;
    hi_bit_nxt      = hi_bit;
    is_rd_nxt       = is_rd;
    phy_sr_nxt      = phy_sr;
    shift_nxt       = shift;
    mdio_o_nxt      = mdio_o;
    mdio_oe_nxt     = mdio_oe;
    reg_addr_nxt    = reg_addr;
    reg_wr_en_nxt   = 1'b0;
    reg_wr_data_nxt = reg_wr_data;
    frame_err_nxt   = 1'b0;

    if (mdc_rise) begin
      unique case (state)
        S_IDLE: begin
          if (mdio_bit) begin
            if (!pre_sat) pre_cnt_nxt = pre_cnt + PRE_W'(1);
          end else begin
            pre_cnt_nxt = '0;
            if (pre_sat) state_nxt = S_ST2;
          end
        end

        S_ST2: begin
          if (mdio_bit) begin
            state_nxt = S_OP;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end
        end

        S_OP: begin
          if (bit_cnt == 5'd0) begin
            hi_bit_nxt  = mdio_bit;
            bit_cnt_nxt = 5'd1;
          end else begin
            bit_cnt_nxt = '0;
            if ({hi_bit, mdio_bit} == MDIO_OP_RD) begin
              is_rd_nxt = 1'b1;
              state_nxt = S_PHYAD;
            end else if ({hi_bit, mdio_bit} == MDIO_OP_WR) begin
              is_rd_nxt = 1'b0;
              state_nxt = S_PHYAD;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = S_IDLE;
            end
          end
        end

        // A foreign address still owns the bus for TA+DATA, so ride it out quietly.
        S_PHYAD: begin
          phy_sr_nxt = {phy_sr[2:0], mdio_bit};
          if (bit_cnt == PHY_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = ({phy_sr, mdio_bit} == PHY_ADDR) ? S_REGAD : S_SKIP;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end

        S_REGAD: begin
          reg_addr_nxt = {reg_addr[3:0], mdio_bit};
          if (bit_cnt == REG_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = is_rd ? S_RD_TA : S_WR_TA;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end

        S_RD_TA: begin
          if (bit_cnt != TA_LAST) begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end else begin
            bit_cnt_nxt = '0;
            mdio_oe_nxt = 1'b1;
            mdio_o_nxt  = 1'b0;
            shift_nxt   = reg_rd_data;
            state_nxt   = S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (bit_cnt == RD_END) begin
            mdio_oe_nxt = 1'b0;
            mdio_o_nxt  = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            mdio_o_nxt  = shift[15];
            shift_nxt   = {shift[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end

        S_WR_TA: begin
          if (bit_cnt != TA_LAST) begin
            hi_bit_nxt  = mdio_bit;
            bit_cnt_nxt = bit_cnt + 5'd1;
          end else if (hi_bit && !mdio_bit) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_WR_DATA;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end
        end

        S_WR_DATA: begin
          shift_nxt = {shift[14:0], mdio_bit};
          if (bit_cnt == DATA_LAST) begin
            reg_wr_data_nxt = {shift[14:0], mdio_bit};
            reg_wr_en_nxt   = 1'b1;
            state_nxt       = S_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end

        S_SKIP: begin
          if (bit_cnt == SKIP_LAST) state_nxt = S_IDLE;
          else                      bit_cnt_nxt = bit_cnt + 5'd1;
        end

        default: state_nxt = S_IDLE;
      endcase

      if (state_nxt == S_IDLE) bit_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a bit-level MDIO master, a frame-level reference model and a scoreboard.
module tb_mdio_responder;

  localparam int         HALF    = 8;
  localparam int         MIN_PRE = 32;
  localparam logic [4:0] MY_PHY  = 5'd1;

  typedef enum logic [1:0] {K_NONE, K_RD, K_WR, K_ERR} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mdCLK = 1'b1;
  logic        master_val = 1'b1;
  logic        mdio_i;
  logic        mdio_o, mdio_oe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        busy, frame_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  logic [15:0] env_bank[32];
  logic [15:0] model_bank[32];
  logic [15:0] rd_scramble = '0;
  bit          abort_mode = 1'b0;

  mdio_responder #(.PHY_ADDR(MY_PHY), .PREAMBLE_LEN(MIN_PRE)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mdCLK       (mdCLK),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .reg_addr    (reg_addr),
    .reg_rd_data (reg_rd_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 CLK = ~CLK;

  // Open-drain style bus: responder wins when it drives, otherwise the master/pull-up.
  assign mdio_i      = mdio_oe ? mdio_o : master_val;
  assign reg_rd_data = env_bank[reg_addr] ^ rd_scramble;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_match(input kind_t k, input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected no event", k, a, d);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == K_RD || e.kind == K_WR) begin
        check("event_addr", 32'(a), 32'(e.addr));
        check("event_data", 32'(d), 32'(e.data));
      end
    end
  endtask

  // Frame-level outcome straight from the protocol rules.
  function automatic exp_t model(input int pre, input logic [1:0] st, input logic [1:0] op,
                                 input logic [4:0] phy, input logic [4:0] regad,
                                 input logic [1:0] ta, input logic [15:0] data);
    exp_t e;
    e.kind = K_NONE;
    e.addr = regad;
    e.data = data;
    if (pre < MIN_PRE)            e.kind = K_NONE;
    else if (st != 2'b01)         e.kind = K_ERR;
    else if (op == 2'b10) begin
      if (phy == MY_PHY) begin
        e.kind = K_RD;
        e.data = model_bank[regad];
      end
    end else if (op == 2'b01) begin
      if (phy != MY_PHY)          e.kind = K_NONE;
      else if (ta != 2'b10)       e.kind = K_ERR;
      else                        e.kind = K_WR;
    end else                      e.kind = K_ERR;
    return e;
  endfunction

  task automatic mdc_bit(input logic b);
    @(negedge CLK);
    mdCLK      = 1'b0;
    master_val = b;
    repeat (HALF) @(negedge CLK);
    mdCLK = 1'b1;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regad,
                            input logic [1:0] ta, input logic [15:0] data, input int stop_after);
    exp_t        e;
    logic [13:0] hdr;
    logic [17:0] tail;
    bit          rd;
    bit          busy_exp;
    int          n;
    e        = model(pre, st, op, phy, regad, ta, data);
    hdr      = {st, op, phy, regad};
    tail     = {ta, data};
    rd       = (op == 2'b10);
    busy_exp = (pre >= MIN_PRE) && (st == 2'b01) && (op == 2'b10 || op == 2'b01);
    if (e.kind != K_NONE && stop_after == 0) sb_q.push_back(e);
    for (int i = 0; i < pre; i++) mdc_bit(1'b1);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i]);
    check("busy_mid", 32'(busy), 32'(busy_exp));
    n = rd ? 19 : 18;
    if (stop_after > 0) n = stop_after;
    for (int i = 0; i < n; i++) mdc_bit(rd ? 1'b1 : tail[17-i]);
    if (stop_after == 0) begin
      repeat (4) @(negedge CLK);
      check("busy_end", 32'(busy), 32'(0));
      check("sb_drained", 32'(sb_q.size()), 32'(0));
      sb_q.delete();
      if (e.kind == K_WR) model_bank[regad] = data;
    end
  endtask

  // Read monitor: captures what the master would sample while the responder drives.
  initial begin : rd_mon
    logic [16:0] got;
    bit          oe_ok;
    forever begin
      @(posedge mdio_oe);
      if (abort_mode) begin
        @(negedge mdio_oe);
      end else begin
        rd_scramble = 16'hA5C3 ^ 16'($urandom_range(0, 255));
        oe_ok = 1'b1;
        for (int i = 16; i >= 0; i--) begin
          @(posedge mdCLK);
          got[i] = mdio_i;
          if (mdio_oe !== 1'b1) oe_ok = 1'b0;
        end
        repeat (6) @(negedge CLK);
        check("rd_oe_window", {30'd0, oe_ok, mdio_oe}, 32'b10);
        rd_scramble = '0;
        check("rd_ta_bit", 32'(got[16]), 32'(0));
        sb_match(K_RD, reg_addr, got[15:0]);
      end
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b0 && reg_wr_en === 1'b1) begin
      env_bank[reg_addr] = reg_wr_data;
      sb_match(K_WR, reg_addr, reg_wr_data);
    end
    if (RST === 1'b0 && frame_err === 1'b1) sb_match(K_ERR, 5'd0, 16'd0);
  end

  initial begin : watchdog
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    int          r;
    logic [4:0]  phy, regad;
    logic [1:0]  op;
    logic [15:0] data;
    for (int i = 0; i < 32; i++) begin
      env_bank[i]   = 16'($urandom);
      model_bank[i] = env_bank[i];
    end
    env_bank[2]   = 16'h0141;
    model_bank[2] = 16'h0141;

    repeat (3) @(negedge CLK);
    check("rst_mdio_o", 32'(mdio_o), 32'(1));
    check("rst_mdio_oe", 32'(mdio_oe), 32'(0));
    check("rst_reg_addr", 32'(reg_addr), 32'(0));
    check("rst_wr_en", 32'(reg_wr_en), 32'(0));
    check("rst_wr_data", 32'(reg_wr_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    send_frame(32, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 0);   // read hit
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'h00, 2'b10, 16'h1200, 0);   // write hit
    send_frame(31, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 0);   // short preamble
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'h00, 2'b00, 16'h0000, 0);   // answered, reads back 1200
    send_frame(32, 2'b01, 2'b10, 5'd7, 5'h02, 2'b00, 16'h0000, 0);   // address mismatch
    send_frame(32, 2'b01, 2'b11, 5'd1, 5'h03, 2'b10, 16'h5A5A, 0);   // OP=11
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'h04, 2'b11, 16'hBEEF, 0);   // write with TA=11
    send_frame(33, 2'b00, 2'b01, 5'd1, 5'h04, 2'b10, 16'h0F0F, 0);   // bad ST

    // Reset during RD_DATA bit 8.
    abort_mode = 1'b1;
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 10);
    check("pre_rst_oe", 32'(mdio_oe), 32'(1));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_mid_oe", 32'(mdio_oe), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_mdio_o", 32'(mdio_o), 32'(1));
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    abort_mode = 1'b0;
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 0);

    for (int f = 0; f < 14; f++) begin
      r     = int'($urandom_range(0, 9));
      regad = 5'($urandom);
      data  = 16'($urandom);
      phy   = MY_PHY;
      op    = 2'b10;
      if (r <= 3)      op = 2'b10;
      else if (r <= 6) op = 2'b01;
      else if (r == 7) begin
        op  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        phy = 5'($urandom_range(2, 31));
      end else if (r == 8) begin
        op  = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      end
      if (r == 9) begin
        if ($urandom_range(0, 1) != 0)
          send_frame(32 + int'($urandom_range(0, 3)), 2'b00, 2'b10, phy, regad, 2'b10, data, 0);
        else
          send_frame(32 + int'($urandom_range(0, 3)), 2'b01, 2'b01, phy, regad,
                     2'($urandom_range(0, 1)), data, 0);
      end else begin
        send_frame(32 + int'($urandom_range(0, 3)), 2'b01, op, phy, regad, 2'b10, data, 0);
      end
    end

    repeat (10) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
